// File: rtl/top_cpu_0_cpu_mul_combine.sv
// top_cpu_0_cpu_mul_combine
//
// Sequencer that builds 32-bit multiply results out of an external
// 16x16 multiplier cell. The cell returns three partial products one cycle
// after it is enabled:
//   cell_p1 = src1[15:0]  * src2[15:0]
//   cell_p2 = src1[15:0]  * src2[31:16]
//   cell_p3 = src1[31:16] * src2[15:0]
// The first pass (operands a, b) yields the low word directly. The mulx*
// operations need a second pass (operands a_hi, b_hi) so that cell_p1 then
// carries a_hi*b_hi. The signed high words are derived from the unsigned
// high word by subtracting the operands whose sign bits are set.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : request pulse, sampled only in IDLE
//   op         : 00 mul (low word), 01 mulxuu, 10 mulxss, 11 mulxsu
//   a, b       : 32-bit operands, captured with start
//   cell_src1  : operand 1 to the multiplier cell (0 when cell_en=0)
//   cell_src2  : operand 2 to the multiplier cell (0 when cell_en=0)
//   cell_en    : multiplier cell register enable
//   cell_p1..3 : partial products from the cell
//   busy       : high whenever the sequencer is not IDLE
//   done       : one-cycle pulse, result valid in that cycle
//   result     : product word, held until the next done

module top_cpu_0_cpu_mul_combine (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP1 = 2'd1,
    CAP2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] ll_q, ll_d;
  logic [32:0] mid_q, mid_d;
  logic [31:0] result_q, result_d;

  logic [32:0] mid_sum;
  logic [33:0] carry_sum;
  logic [31:0] uhi;
  logic [31:0] corr_a;
  logic [31:0] corr_b;

  // Next-state and cell drive logic. The cell operands are combinational so
  // the cell captures them on the same edge that moves the FSM; its products
  // are then available in the following state.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    ll_d      = ll_q;
    mid_d     = mid_q;
    result_d  = result_q;
    cell_en   = 1'b0;
    cell_src1 = 32'h0;
    cell_src2 = 32'h0;

    // Cross terms of the first pass; 33 bits so the carry is kept.
    mid_sum   = {1'b0, cell_p2} + {1'b0, cell_p3};

    // Unsigned high word: a_hi*b_hi plus everything that carries out of
    // bit 31 of the low half (mid shifted by 16 plus the top of ll).
    carry_sum = {1'b0, mid_q} + {18'h0, ll_q[31:16]};
    uhi       = cell_p1 + 32'(carry_sum >> 16);

    // Two's complement correction terms for the signed variants.
    corr_a    = b_q[31] ? a_q : 32'h0;
    corr_b    = a_q[31] ? b_q : 32'h0;

    unique case (state_q)
      IDLE: begin
        // reset_n gating keeps the cell quiet while reset is held.
        if (start && reset_n) begin
          a_d       = a;
          b_d       = b;
          op_d      = op;
          cell_en   = 1'b1;
          cell_src1 = a;
          cell_src2 = b;
          state_d   = CAP1;
        end
      end
      CAP1: begin
        ll_d  = cell_p1;
        mid_d = mid_sum;
        if (op_q == OP_MUL) begin
          // Low word only needs bits [15:0] of the cross-term sum.
          result_d = cell_p1 + 32'(mid_sum << 16);
          state_d  = DONE;
        end else begin
          cell_en   = 1'b1;
          cell_src1 = {16'h0, a_q[31:16]};
          cell_src2 = {16'h0, b_q[31:16]};
          state_d   = CAP2;
        end
      end
      CAP2: begin
        unique case (op_q)
          OP_MULXSS: result_d = uhi - corr_b - corr_a;
          OP_MULXSU: result_d = uhi - corr_b;
          OP_MULXUU: result_d = uhi;
          default:   result_d = uhi;
        endcase
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 2'b00;
      ll_q     <= 32'h0;
      mid_q    <= 33'h0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ll_q     <= ll_d;
      mid_q    <= mid_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_top_cpu_0_cpu_mul_combine.sv
// tb_top_cpu_0_cpu_mul_combine
//
// Bench for the multiply sequencer. A behavioural 16x16 cell answers the
// DUT's cell requests. Expected results come from full-width 64/65-bit
// arithmetic and are queued with the cycle in which done must appear; a
// monitor pops and compares them whenever done is seen.

module tb_top_cpu_0_cpu_mul_combine;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } sb_t;

  sb_t         sb[$];
  vec_t        vecs[17];
  int          cyc;
  int          check_count;
  int          pass_count;
  logic [31:0] last_result;

  top_cpu_0_cpu_mul_combine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cell_src1 (cell_src1),
    .cell_src2 (cell_src2),
    .cell_en   (cell_en),
    .cell_p1   (cell_p1),
    .cell_p2   (cell_p2),
    .cell_p3   (cell_p3),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value k during the cycle that begins at rising edge k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier cell, registered on cell_en.
  initial begin
    cell_p1 = 32'h0;
    cell_p2 = 32'h0;
    cell_p3 = 32'h0;
  end
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  // Reference result from full-width products.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] uu;
    logic [63:0] ss;
    logic [64:0] su;
    uu = {32'h0, x} * {32'h0, y};
    ss = {{32{x[31]}}, x} * {{32{y[31]}}, y};
    su = {{33{x[31]}}, x} * {33'h0, y};
    case (o)
      2'b00:   return uu[31:0];
      2'b01:   return uu[63:32];
      2'b10:   return ss[63:32];
      default: return su[63:32];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one request for one cycle, then scramble the inputs so that any
  // late sampling of a/b/op corrupts the result.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    sb_t ent;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    ent.res = e;
    ent.cyc = cyc + ((o == 2'b00) ? 2 : 3);
    sb.push_back(ent);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic waitDone();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  // Monitor: compare on done, otherwise result must hold its last value.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_result = 32'h0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", {31'h0, done}, 32'h0);
      end else begin
        sb_t ent;
        ent = sb.pop_front();
        checkOutput("done_result", result, ent.res);
        checkOutput("done_cycle", 32'(cyc), 32'(ent.cyc));
      end
      last_result = result;
    end else begin
      checkOutput("result_hold", result, last_result);
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sb_t ent;
    check_count = 0;
    pass_count  = 0;
    last_result = 32'h0;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    a       = 32'h0;
    b       = 32'h0;

    vecs[0] = '{2'b00, 32'h00012345, 32'h00010000, 32'h23450000};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{2'b10, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000};
    vecs[5] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001};
    vecs[6] = '{2'b00, 32'h00000003, 32'h00000005, 32'h0000000F};
    vecs[7] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[8] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, model(2'b11, 32'h80000000, 32'hFFFFFFFF)};
    for (int i = 9; i < 17; i++) begin
      vecs[i].op  = 2'(i % 4);
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      vecs[i].exp = model(vecs[i].op, vecs[i].a, vecs[i].b);
    end

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_cell_en", {31'h0, cell_en}, 32'h0);
    checkOutput("reset_result", result, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table vectors, back to back.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      waitDone();
    end

    // cell_en/cell_src timing of a two-pass operation.
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'b01;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    ent.res = 32'hFFFFFFFE;
    ent.cyc = cyc + 3;
    sb.push_back(ent);
    @(negedge clk);
    checkOutput("t0_cell_en", {31'h0, cell_en}, 32'h1);
    checkOutput("t0_cell_src1", cell_src1, 32'hFFFFFFFF);
    checkOutput("t0_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'b00;
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    @(negedge clk);
    checkOutput("t1_cell_en", {31'h0, cell_en}, 32'h1);
    checkOutput("t1_cell_src1", cell_src1, 32'h0000FFFF);
    checkOutput("t1_cell_src2", cell_src2, 32'h0000FFFF);
    @(negedge clk);
    checkOutput("t2_cell_en", {31'h0, cell_en}, 32'h0);
    checkOutput("t2_cell_src1", cell_src1, 32'h0);
    checkOutput("t2_cell_src2", cell_src2, 32'h0);
    waitDone();

    // Starts while busy are ignored and busy stays high through DONE.
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'b01;
    a = 32'h00010000;
    b = 32'h00010000;
    ent.res = 32'h00000001;
    ent.cyc = cyc + 3;
    sb.push_back(ent);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      start = (k < 3);
      op = 2'b10;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      checkOutput("busy_hold", {31'h0, busy}, 32'h1);
    end
    waitDone();
    repeat (2) @(negedge clk);

    // Reset during CAP2 abandons the operation.
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'b01;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cap2_busy", {31'h0, busy}, 32'h1);
    reset_n = 1'b0;
    start = 1'b1;
    #1;
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_cell_en", {31'h0, cell_en}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_start_ignored", {31'h0, busy | cell_en}, 32'h0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_rst_idle", {31'h0, busy}, 32'h0);
    applyStimulus(2'b00, 32'h3, 32'h5, 32'h0000000F);
    waitDone();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/top_cpu_0_cpu_mul_combine.md
TOP_CPU_0_CPU_MUL_COMBINE -- requirements
Module: top_cpu_0_cpu_mul_combine

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and 16x16 partial products.
REQ-002 clk  input  1  single clock; every register SHALL be clocked on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request pulse; SHALL be sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 mul (low word), 01 mulxuu, 10 mulxss, 11 mulxsu (a signed, b unsigned).
REQ-006 a, b  input  32 each  operands; SHALL be sampled with start.
REQ-007 cell_src1, cell_src2  output  32 each  operands driven to the multiplier cell.
REQ-008 cell_en  output  1  multiplier cell register enable.
REQ-009 cell_p1, cell_p2, cell_p3  input  32 each  cell products: lo*lo, src1lo*src2hi, src1hi*src2lo; valid one cycle after cell_en=1.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-012 result  output  32  product word; SHALL hold its value until the next done.

Function
REQ-013 The FSM SHALL have states IDLE, CAP1, CAP2 and DONE.
REQ-014 In IDLE, start=1 SHALL latch a, b and op, drive cell_src1=a, cell_src2=b, assert cell_en, and move to CAP1.
REQ-015 In CAP1, the block SHALL register ll=cell_p1 and mid=cell_p2+cell_p3 (33-bit, carry kept).
REQ-016 In CAP1 with op=00, the block SHALL move to DONE with result=(ll+(mid<<16)) mod 2^32.
REQ-017 In CAP1 with op!=00, the block SHALL drive cell_src1={16'h0,a[31:16]} and cell_src2={16'h0,b[31:16]}, assert cell_en, and move to CAP2.
REQ-018 In CAP2, the block SHALL compute uhi=cell_p1+((mid+(ll>>16))>>16) mod 2^32.
REQ-019 In CAP2, result SHALL be set per op: mulxuu=uhi; mulxsu=uhi-(a[31]?b:0); mulxss=uhi-(a[31]?b:0)-(b[31]?a:0); all mod 2^32.
REQ-020 After CAP2 the FSM SHALL move to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 From IDLE, a new start SHALL be accepted in the cycle after DONE.
REQ-023 Latency SHALL be fixed: with start at cycle T, done occurs at T+2 for mul and T+3 for mulx*.
REQ-024 cell_en SHALL be 0 in all states other than those named in REQ-014 and REQ-017.
REQ-025 cell_src* SHALL be 0 whenever cell_en=0.
REQ-026 start while busy=1 SHALL be ignored with no side effect, and latched operands SHALL NOT change.
REQ-027 Inputs a, b and op changing after the start cycle SHALL NOT affect the result.

Reset
REQ-028 reset_n=0 SHALL immediately force state=IDLE and busy=0, done=0, cell_en=0, result=0, and clear all internal registers, regardless of cycle phase.
REQ-029 An operation interrupted by reset SHALL be abandoned: no done after release, and the next start after release SHALL behave normally.
REQ-030 start SHALL be ignored while reset_n=0.

Verification
REQ-031 op=00, a=0x00012345, b=0x00010000 -> done at T+2, result=0x23450000.
REQ-032 op=01, a=b=0xFFFFFFFF -> done at T+3, result=0xFFFFFFFE; cell_en high exactly at T and T+1.
REQ-033 op=10, a=b=0xFFFFFFFF -> result=0x00000000; op=11, a=b=0xFFFFFFFF -> result=0xFFFFFFFF.
REQ-034 op=10, a=0x80000000, b=0x7FFFFFFF -> result=0xC0000000; op=01, a=0x00010000, b=0x00010000 -> result=0x00000001.
REQ-035 Start op=01, then pulse start with different operands at T+1 and T+2 -> only the first result is produced, and busy is continuous T+1..T+3.
REQ-036 Assert reset_n=0 in CAP2 -> result=0 and done=0 at once; after release, start op=00 with a=3, b=5 -> result=0x0000000F at T+2.
